sdram_bist: RTL
===============

SDRAM_BIST -- requirements
Module: sdram_bist

Interface
REQ-001 Parameter ADDR_BASE, 32'h0, first word address tested.
REQ-002 Parameter WORDS, 1024, number of words written then read (1..65535).
REQ-003 Parameter SEED, 32'h1, LFSR seed; value 0 is replaced by 1.
REQ-004 Port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port start, input, 1, one-cycle request to begin a test run.
REQ-007 Port o_valid, output, 1, request valid toward sys_sdram i_valid.
REQ-008 Port i_ready, input, 1, transfer-complete from sys_sdram o_ready.
REQ-009 Port o_addr, output, 32, word address toward i_addr.
REQ-010 Port o_wdata, output, 32, write data toward i_wdata.
REQ-011 Port o_wstrb, output, 4, byte strobes; 4'hF = write, 4'h0 = read.
REQ-012 Port i_rdata, input, 32, read data from o_rdata; valid in the i_ready cycle.
REQ-013 Port busy, output, 1, high while a run is in progress.
REQ-014 Port done, output, 1, high from run end until the next accepted start.
REQ-015 Port pass, output, 1, valid while done; high when err_count == 0.
REQ-016 Port err_count, output, 16, saturating count of miscompares.
REQ-017 Port err_addr, output, 32, address of the first miscompare of the run.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE, READ, FIN.
- IDLE→WRITE on start.
- WRITE→READ after the WORDS-th accepted write.
- READ→FIN after the WORDS-th accepted read.
- FIN→WRITE on start.
REQ-019 A transfer SHALL complete only in a cycle with o_valid && i_ready; o_addr/o_wdata/o_wstrb SHALL be held stable while o_valid is high and i_ready is low.
REQ-020 o_valid SHALL be high in every WRITE and READ cycle, including the cycle after a completed transfer (back-to-back), and low in IDLE and FIN.
REQ-021 A 16-bit index SHALL reset to 0 on entry to WRITE and to READ and increment per completed transfer; o_addr = ADDR_BASE + index, modulo 2^32 (wraps).
REQ-022 Pattern data SHALL be regenerated from the same initial state at entry to WRITE and to READ, and advance once per completed transfer, so read word n is compared against write word n.
REQ-023 In READ, on each completed transfer, i_rdata != expected SHALL increment err_count (saturating at 16'hFFFF); the first miscompare of the run SHALL load err_addr.
REQ-024 Accepting start SHALL clear err_count, err_addr, done, and pass in the same cycle; start in WRITE or READ SHALL be ignored.
REQ-025 Entry to FIN SHALL set done = 1 and pass = (err_count == 0), including the final comparison; busy SHALL be high exactly in WRITE and READ.
REQ-026 If i_ready is asserted while o_valid is low, it SHALL be ignored.

Reset
REQ-027 rst SHALL force, asynchronously, state = IDLE, index = 0, o_valid = 0, o_addr = ADDR_BASE, o_wdata = 0, o_wstrb = 0, busy = 0, done = 0, pass = 0, err_count = 0, err_addr = 0, LFSR = SEED (or 1).
REQ-028 rst mid-run SHALL abandon the run with no further requests; a fresh start is required afterwards.

Configuration
REQ-029 With macro SDRAM_BIST_LFSR_EN defined, the pattern SHALL be a 32-bit Fibonacci LFSR.
- Taps 32, 22, 2, 1.
- Initial state SEED (0 becomes 1).
- Word n = LFSR state after n shifts.
REQ-030 Without SDRAM_BIST_LFSR_EN, the pattern SHALL be o_addr XOR 32'hA5A5_5A5A, and no LFSR register SHALL be instantiated.

Verification
REQ-031 WORDS=4, ADDR_BASE=0, ideal memory model, i_ready always 1.
- Expect writes to addresses 0..3, then reads of 0..3 in consecutive cycles.
- Expect done=1, pass=1, err_count=0.
REQ-032 Model inserts 3 wait cycles per transfer.
- Expect addr/wdata/wstrb stable during each wait.
- Expect exactly 8 completed transfers and pass=1.
REQ-033 Model corrupts read data at addresses 2 and 3 (bit 0 flipped).
- Expect err_count=2, err_addr=2, pass=0.
REQ-034 ADDR_BASE=32'hFFFF_FFFE, WORDS=4.
- Expect addresses FFFF_FFFE, FFFF_FFFF, 0, 1.
REQ-035 Assert rst for 1 cycle during the 2nd read.
- Expect o_valid=0 immediately and state IDLE.
- Expect a subsequent start to rerun from index 0.
REQ-036 Pulse start during WRITE.
- Expect it ignored and the run completed unchanged.
- Build both with and without SDRAM_BIST_LFSR_EN; expect pass=1 on the ideal model in both.

Source files
------------

// File: rtl/sdram_bist.sv
// sdram_bist: write-then-read memory self test driving a sys_sdram style
// valid/ready request port. Writes WORDS pattern words starting at ADDR_BASE,
// reads them back and counts miscompares.
// Build option: define SDRAM_BIST_LFSR_EN for a 32-bit Fibonacci LFSR
// pattern (taps 32,22,2,1); otherwise the pattern is address ^ 32'hA5A5_5A5A.
module sdram_bist #(
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter int unsigned WORDS     = 1024,
    parameter logic [31:0] SEED      = 32'h1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_addr,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    input  logic [31:0] i_rdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] err_addr
);

    localparam int unsigned IW = 16;
    localparam int unsigned EW = 16;
    localparam int unsigned DW = 32;
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, FIN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   index_q;
    logic            xfer, last, enter_run, start_acc, err_hit, fin_entry;
    logic [EW-1:0]   err_count_d;
    logic [DW-1:0]   pat_cur, pat_first, pat_next;

`ifdef SDRAM_BIST_LFSR_EN
    localparam logic [DW-1:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    logic [DW-1:0] lfsr_q;

    assign pat_cur   = lfsr_q;
    assign pat_first = SEED_EFF;
    assign pat_next  = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

    // Pattern generator: restart from seed at each phase entry, shift per transfer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED_EFF;
        end else if (enter_run) begin
            lfsr_q <= SEED_EFF;
        end else if (xfer) begin
            lfsr_q <= pat_next;
        end
    end
`else
    localparam logic [DW-1:0] PAT_KEY = 32'hA5A5_5A5A;

    assign pat_cur   = o_addr ^ PAT_KEY;
    assign pat_first = ADDR_BASE ^ PAT_KEY;
    assign pat_next  = (o_addr + DW'(1)) ^ PAT_KEY;
`endif

    assign xfer = o_valid && i_ready;
    assign last = (index_q == LAST_IDX);

    // Next-state and per-cycle control decode
    always_comb begin
        state_d     = state_q;
        start_acc   = 1'b0;
        err_hit     = 1'b0;
        err_count_d = err_count;
        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    state_d   = WRITE;
                    start_acc = 1'b1;
                end
            end
            WRITE: begin
                if (xfer && last) state_d = READ;
            end
            READ: begin
                if (xfer && last) state_d = FIN;
                if (xfer && (i_rdata != pat_cur)) begin
                    err_hit = 1'b1;
                    if (err_count != '1) err_count_d = err_count + EW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        enter_run = (state_d != state_q) && ((state_d == WRITE) || (state_d == READ));
        fin_entry = (state_q == READ) && (state_d == FIN);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request port, index and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_q   <= '0;
            o_valid   <= 1'b0;
            o_addr    <= ADDR_BASE;
            o_wdata   <= '0;
            o_wstrb   <= 4'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            o_valid <= (state_d == WRITE) || (state_d == READ);
            busy    <= (state_d == WRITE) || (state_d == READ);
            o_wstrb <= (state_d == WRITE) ? 4'hF : 4'h0;
            if (enter_run) begin
                index_q <= '0;
                o_addr  <= ADDR_BASE;
                o_wdata <= (state_d == WRITE) ? pat_first : '0;
            end else if (xfer) begin
                index_q <= index_q + IW'(1);
                o_addr  <= o_addr + DW'(1);
                o_wdata <= (state_q == WRITE) ? pat_next : '0;
            end
            if (start_acc) begin
                err_count <= '0;
                err_addr  <= '0;
                done      <= 1'b0;
                pass      <= 1'b0;
            end else begin
                err_count <= err_count_d;
                if (err_hit && (err_count == '0)) err_addr <= o_addr;
                if (fin_entry) begin
                    done <= 1'b1;
                    pass <= (err_count_d == '0);
                end
            end
        end
    end

endmodule
